// File: rtl/block_data_memory.sv
// rtl/block_data_memory.sv - block-addressed main memory responder with programmable access latency
// Optional MEM_ACCESS_COUNT_EN adds saturating read/write commit counters.
module block_data_memory #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [DATA_WIDTH-1:0] mem_writedata,
  output logic [DATA_WIDTH-1:0] mem_readdata,
  output logic                  mem_busywait
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [3:0]              r_count;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_op_write;
  logic [DATA_WIDTH-1:0]   r_readdata;
  logic [DATA_WIDTH-1:0]   r_mem [2**ADDR_WIDTH];
  logic                    w_request;
  logic                    w_accept;
  logic                    w_commit;
  logic                    w_busywait;

  assign w_request = mem_read | mem_write;
  assign w_accept  = (r_state == IDLE) && w_request;
  assign w_commit  = (r_state == BUSY) && (r_count == 4'd0);

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Busywait rises combinationally on a new request so the requester never sees a stale low.
  always_comb begin
    w_state_next = r_state;
    w_busywait   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_request) begin
          w_busywait   = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        w_busywait = 1'b1;
        if (r_count == 4'd0) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (reset) w_busywait = 1'b0;
  end

  assign mem_busywait = w_busywait;

  // A simultaneous read+write is taken as a write; the read is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count    <= 4'd0;
      r_readdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= mem_address;
        r_data     <= mem_writedata;
        r_op_write <= mem_write;
        r_count    <= COUNT_LOAD;
      end else if (r_state == BUSY && r_count != 4'd0) begin
        r_count <= r_count - 4'd1;
      end
      if (w_commit && !r_op_write) r_readdata <= r_mem[r_addr];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_commit && r_op_write) r_mem[r_addr] <= r_data;
  end

  assign mem_readdata = r_readdata;

`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] r_read_count;
  logic [15:0] r_write_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_count  <= 16'd0;
      r_write_count <= 16'd0;
    end else if (w_commit) begin
      if (r_op_write) begin
        if (r_write_count != 16'hFFFF) r_write_count <= r_write_count + 16'd1;
      end else begin
        if (r_read_count != 16'hFFFF) r_read_count <= r_read_count + 16'd1;
      end
    end
  end

  assign read_count  = r_read_count;
  assign write_count = r_write_count;
`endif

endmodule

// File: doc/block_data_memory.md
Name: block_data_memory

Overview:
- Main-memory responder for the data cache's refill/write-back interface. Stores 64 blocks of 32 bits, addressed by block (6-bit).
- Serves one block read or one block write per request.
- Holds mem_busywait high for a programmable access latency, then completes the access and releases the requester.
- Sits below the data cache in the single-cycle processor's memory hierarchy.

Parameters:
- ADDR_WIDTH, 6: block address width; depth = 2**ADDR_WIDTH blocks.
- DATA_WIDTH, 32: block width in bits.
- LATENCY, 5: cycles from request acceptance to completion. Legal range 1..15.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high.
- mem_read  input  1  block read request; held by requester until it sees mem_busywait low.
- mem_write  input  1  block write request; same hold rule.
- mem_address  input  ADDR_WIDTH  block address (tag,index).
- mem_writedata  input  DATA_WIDTH  block to write.
- mem_readdata  output  DATA_WIDTH  registered read block.
- mem_busywait  output  1  requester must stall while high.

Behaviour:
- Storage: array of 2**ADDR_WIDTH x DATA_WIDTH registers. Reset does not clear contents. Read-before-write is never required.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If mem_read or mem_write is high, mem_busywait asserts combinationally in the same cycle, so the requester never samples a false "done".
  - At the posedge with a request: latch mem_address, mem_writedata and op; load counter = LATENCY-1; go to BUSY.
  - Simultaneous mem_read and mem_write: treated as a write. The read is dropped.
- BUSY:
  - mem_busywait = 1. Counter decrements each posedge.
  - At the posedge where counter == 0, the access commits:
    - Read: mem_readdata <= array[latched addr].
    - Write: array[latched addr] <= latched data.
  - Then go to DONE.
  - Latched address/data are used throughout. Input changes during BUSY are ignored.
- DONE:
  - mem_busywait = 0 for exactly one cycle. mem_readdata is valid and holds until the next read commit.
  - Requests present in DONE are not accepted; they are the completing request still held.
  - Always go to IDLE next.
  - A back-to-back request, e.g. write-back followed by refill, is accepted from IDLE one cycle later.
- Latency: request visible in cycle 0 → completion in the DONE cycle, at cycle LATENCY+1. mem_busywait is high for LATENCY+1 cycles.
- LATENCY=1: BUSY lasts one cycle (counter loads 0).
- Reset (synchronous):
  - state <= IDLE, counter <= 0, mem_readdata <= 0. mem_busywait reads 0 while reset is high.
  - Reset during BUSY aborts the access: no array write, mem_readdata unchanged from its reset value.
- Address wrap: none needed; every ADDR_WIDTH value is a valid block.

Optional Feature:
- Macro MEM_ACCESS_COUNT_EN.
- Defined: adds outputs read_count[15:0] and write_count[15:0].
  - Each increments by 1 on the posedge a read/write commits.
  - Both saturate at 16'hFFFF. Both clear on reset.
  - A simultaneous read+write request counts as a write only.
- Undefined: ports and counters are absent. Core behaviour is identical.

Test Plan:
- Reset, then mem_write=1, addr=6'h0A, data=32'hDEADBEEF, LATENCY=5 → mem_busywait high for 6 cycles, low in DONE; hold request until then, then deassert.
- mem_read=1, addr=6'h0A → mem_busywait high for 6 cycles. In DONE, mem_readdata=32'hDEADBEEF.
- Write addr 6'h3F data 32'h12345678, then read 6'h3F back-to-back (read asserted the cycle after DONE) → read accepted from IDLE, returns 32'h12345678. Verify no lost or duplicated access.
- Change mem_address to 6'h01 and mem_writedata to 0 mid-BUSY of a write to 6'h05 with data 32'hA5A5A5A5 → 6'h05 holds 32'hA5A5A5A5, 6'h01 unchanged.
- Assert reset two cycles into a write to 6'h07 with data 32'hFFFF0000 → busywait 0, state IDLE. A later read of 6'h07 returns its prior contents.
- MEM_ACCESS_COUNT_EN defined, LATENCY=1: three reads, then two writes, then one simultaneous read+write → read_count=3, write_count=3. Each access shows busywait high for 2 cycles.
